// File: rtl/sd_block_arbiter_if.sv
// sd_block_arbiter_if
// Bundles the requester-side and engine-side signals of the SD block arbiter.
//   master : the arbiter (drives gnt/done/err, engine strobes, routed handshakes)
//   slave  : the environment (requesters plus the SD block engine)
// Requester side : req, req_wr, req_addr, gnt, done, err, err_code,
//                  req_din, req_din_valid, req_din_taken,
//                  req_dout, req_dout_avail, req_dout_taken
// Engine side    : eng_rd, eng_wr, eng_addr, eng_busy, eng_error, eng_error_code,
//                  eng_din, eng_din_valid, eng_din_taken,
//                  eng_dout, eng_dout_avail, eng_dout_taken
// Debug          : dbg_state (arbiter FSM state)
//
// Handshakes: a write byte moves when din_valid is high and the engine pulses
// din_taken; a read byte moves when dout_avail is high and the requester pulses
// dout_taken. Each taken pulse must return low for at least one clock between
// bytes, because the arbiter counts bytes on taken rising edges. req is a level
// held from request until the matching done pulse.
interface sd_block_arbiter_if #(parameter int NREQ = 2);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_wr;
  logic [NREQ*32-1:0]   req_addr;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic                 err;
  logic [2:0]           err_code;
  logic [NREQ*8-1:0]    req_din;
  logic [NREQ-1:0]      req_din_valid;
  logic [NREQ-1:0]      req_din_taken;
  logic [7:0]           req_dout;
  logic [NREQ-1:0]      req_dout_avail;
  logic [NREQ-1:0]      req_dout_taken;
  logic                 eng_rd;
  logic                 eng_wr;
  logic [31:0]          eng_addr;
  logic                 eng_busy;
  logic                 eng_error;
  logic [2:0]           eng_error_code;
  logic [7:0]           eng_din;
  logic                 eng_din_valid;
  logic                 eng_din_taken;
  logic [7:0]           eng_dout;
  logic                 eng_dout_avail;
  logic                 eng_dout_taken;
  logic [2:0]           dbg_state;

  modport master (
    input  req, req_wr, req_addr, req_din, req_din_valid, req_dout_taken,
    input  eng_busy, eng_error, eng_error_code, eng_din_taken, eng_dout, eng_dout_avail,
    output gnt, done, err, err_code, req_din_taken, req_dout, req_dout_avail,
    output eng_rd, eng_wr, eng_addr, eng_din, eng_din_valid, eng_dout_taken,
    output dbg_state
  );

  modport slave (
    output req, req_wr, req_addr, req_din, req_din_valid, req_dout_taken,
    output eng_busy, eng_error, eng_error_code, eng_din_taken, eng_dout, eng_dout_avail,
    input  gnt, done, err, err_code, req_din_taken, req_dout, req_dout_avail,
    input  eng_rd, eng_wr, eng_addr, eng_din, eng_din_valid, eng_dout_taken,
    input  dbg_state
  );
endinterface

// File: rtl/sd_block_arbiter.sv
// sd_block_arbiter
// Shares one SD SPI block engine between NREQ requesters. One requester is
// granted at a time (round-robin), its single-block read or write is sequenced
// through the engine, its byte streams are routed, and a one-cycle done pulse
// with error status ends the transfer.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : sd_block_arbiter_if.master (requester and engine signals, debug state)
// Parameters:
//   NREQ          : number of requesters (2..4)
//   START_TIMEOUT : ISSUE cycles allowed for eng_busy to rise before aborting
module sd_block_arbiter #(
  parameter int NREQ          = 2,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  sd_block_arbiter_if.master  bus
);
  localparam int IW = (NREQ > 2) ? 2 : 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);

  // DRAIN waits for eng_busy to fall after the strobe has been dropped.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            wr_q, wr_d;
  logic [31:0]     addr_q, addr_d;
  logic            strobe_q, strobe_d;
  logic            gnt_act_q, gnt_act_d;
  logic            err_q, err_d;
  logic [2:0]      code_q, code_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [9:0]      bcnt_q, bcnt_d;
  logic            tk_prev_q;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            tk;
  logic            tk_rise;

  // First requesting index at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    int c;
    c          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      c = (int'(ptr_q) + k) % NREQ;
      if (!pick_found && bus.req[c]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(c);
      end
    end
  end

  // Bytes are counted on the taken edge of the direction in flight.
  assign tk      = wr_q ? bus.eng_din_taken : bus.req_dout_taken[idx_q];
  assign tk_rise = tk & ~tk_prev_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    strobe_d  = strobe_q;
    gnt_act_d = gnt_act_q;
    err_d     = err_q;
    code_d    = code_q;
    tmo_d     = tmo_q;
    bcnt_d    = bcnt_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.eng_busy && pick_found) begin
          idx_d     = pick_idx;
          wr_d      = bus.req_wr[pick_idx];
          addr_d    = bus.req_addr[pick_idx*32 +: 32];
          gnt_act_d = 1'b1;
          strobe_d  = 1'b1;
          err_d     = 1'b0;
          code_d    = 3'b000;
          tmo_d     = '0;
          bcnt_d    = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.eng_busy) begin
          state_d = S_RUN;
        end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
          strobe_d = 1'b0;
          err_d    = 1'b1;
          code_d   = 3'b111;
          state_d  = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RUN: begin
        if (bus.eng_error) begin
          strobe_d = 1'b0;
          err_d    = 1'b1;
          code_d   = bus.eng_error_code;
          state_d  = S_DRAIN;
        end else if (tk_rise) begin
          bcnt_d = bcnt_q + 10'd1;
          if (bcnt_q == 10'd511) begin
            strobe_d = 1'b0;
            state_d  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!bus.eng_busy) begin
          // An error caught in RUN keeps its code; otherwise take the final status.
          if (!err_q) begin
            err_d  = bus.eng_error;
            code_d = bus.eng_error_code;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        gnt_act_d = 1'b0;
        ptr_d     = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      strobe_q  <= 1'b0;
      gnt_act_q <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 3'b000;
      tmo_q     <= '0;
      bcnt_q    <= '0;
      tk_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      strobe_q  <= strobe_d;
      gnt_act_q <= gnt_act_d;
      err_q     <= err_d;
      code_q    <= code_d;
      tmo_q     <= tmo_d;
      bcnt_q    <= bcnt_d;
      tk_prev_q <= tk;
    end
  end

  // Grant, done and byte-stream routing all follow the latched index.
  always_comb begin
    bus.gnt            = '0;
    bus.done           = '0;
    bus.req_din_taken  = '0;
    bus.req_dout_avail = '0;
    bus.eng_din        = 8'h00;
    bus.eng_din_valid  = 1'b0;
    bus.eng_dout_taken = 1'b0;
    if (gnt_act_q) begin
      bus.gnt[idx_q]            = 1'b1;
      bus.eng_din               = bus.req_din[idx_q*8 +: 8];
      bus.eng_din_valid         = bus.req_din_valid[idx_q];
      bus.eng_dout_taken        = bus.req_dout_taken[idx_q];
      bus.req_din_taken[idx_q]  = bus.eng_din_taken;
      bus.req_dout_avail[idx_q] = bus.eng_dout_avail;
    end
    if (state_q == S_DONE) begin
      bus.done[idx_q] = 1'b1;
    end
  end

  assign bus.req_dout  = bus.eng_dout;
  assign bus.eng_rd    = strobe_q & ~wr_q;
  assign bus.eng_wr    = strobe_q & wr_q;
  assign bus.eng_addr  = addr_q;
  assign bus.err       = err_q;
  assign bus.err_code  = code_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_sd_block_arbiter.sv
// tb_sd_block_arbiter
// Drives the arbiter with a cycle-level behavioural engine and requesters.
// Grant order comes from a "next after last served" reference; byte data goes
// through an expected-value queue between the producing and consuming side.
module tb_sd_block_arbiter;
  localparam int NREQ = 2;
  localparam int TMO  = 1024;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [7:0]  exp_q[$];
  int          last_served;
  logic [31:0] cfg_addr [NREQ];
  logic        cfg_wr   [NREQ];
  int          got;

  sd_block_arbiter_if #(.NREQ(NREQ)) bus();

  sd_block_arbiter #(.NREQ(NREQ), .START_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int e);
    oh = '0;
    if (e >= 0 && e < NREQ) oh[e] = 1'b1;
  endfunction

  // Reference: the next requester after the last one served, in circular order.
  function automatic int model_pick(input logic [NREQ-1:0] r);
    model_pick = -1;
    for (int k = NREQ; k >= 1; k--)
      if (r[(last_served + k) % NREQ]) model_pick = (last_served + k) % NREQ;
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    bus.req            = '0;
    bus.req_wr         = '0;
    bus.req_addr       = '0;
    bus.req_din        = '0;
    bus.req_din_valid  = '0;
    bus.req_dout_taken = '0;
    bus.eng_busy       = 1'b0;
    bus.eng_error      = 1'b0;
    bus.eng_error_code = 3'b000;
    bus.eng_din_taken  = 1'b0;
    bus.eng_dout       = 8'h00;
    bus.eng_dout_avail = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_served = NREQ - 1;
    @(negedge clk);
  endtask

  task automatic post(input int r, input logic wr, input logic [31:0] addr);
    cfg_wr[r]             = wr;
    cfg_addr[r]           = addr;
    bus.req_wr[r]         = wr;
    bus.req_addr[r*32 +: 32] = addr;
    bus.req[r]            = 1'b1;
  endtask

  task automatic finish_done(input int e, input logic exp_err, input logic [2:0] exp_code);
    int n;
    n = 0;
    while (bus.done === '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_onehot", bus.done, oh(e));
    chk("err", bus.err, exp_err);
    chk("err_code", bus.err_code, exp_code);
    bus.req[e]  = 1'b0;
    last_served = e;
    @(negedge clk);
    chk("done_single", bus.done, 0);
    chk("gnt_clear", bus.gnt, 0);
  endtask

  // One complete transfer for whichever requester the reference expects.
  task automatic xfer(input int err_at, input int rst_at, input bit no_busy, input int drop_at);
    int e, other, n, strobe_cycles;
    bit is_wr, multi;
    logic [7:0] d;
    e     = model_pick(bus.req);
    other = (e + 1) % NREQ;
    multi = 1'b0;
    got   = -1;
    n = 0;
    while (bus.gnt === '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("grant", bus.gnt, oh(e));
    for (int k = 0; k < NREQ; k++) if (bus.gnt[k] === 1'b1) got = k;
    if (bus.gnt === '0) return;
    is_wr = cfg_wr[e];
    chk("strobe_rd", bus.eng_rd, !is_wr);
    chk("strobe_wr", bus.eng_wr, is_wr);
    chk("eng_addr", bus.eng_addr, cfg_addr[e]);
    // Changes after grant must not reach the engine.
    bus.req_addr[e*32 +: 32] = $urandom;
    bus.req_wr[e]            = ~is_wr;

    if (no_busy) begin
      strobe_cycles = 0;
      n = 0;
      while ((bus.eng_rd | bus.eng_wr) === 1'b1 && n < TMO + 10) begin
        strobe_cycles++;
        @(negedge clk);
        n++;
      end
      chk("tmo_cycles", strobe_cycles, TMO);
      finish_done(e, 1'b1, 3'b111);
      return;
    end

    repeat ($urandom_range(1, 3)) @(negedge clk);
    chk("addr_hold", bus.eng_addr, cfg_addr[e]);
    chk("wr_hold", bus.eng_wr, is_wr);
    bus.eng_busy = 1'b1;
    @(negedge clk);

    for (int b = 0; b < 512; b++) begin
      if (b == err_at) begin
        bus.eng_error      = 1'b1;
        bus.eng_error_code = 3'b010;
        break;
      end
      if (b == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_rd", bus.eng_rd, 0);
        chk("rst_wr", bus.eng_wr, 0);
        chk("rst_done", bus.done, 0);
        repeat (2) @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        last_served = NREQ - 1;
        @(negedge clk);
        return;
      end
      if (b == drop_at) bus.req[e] = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
      if ($countones(bus.gnt) != 1) multi = 1'b1;
      chk("strobe_hold", bus.eng_rd | bus.eng_wr, 1);
      d = 8'($urandom);
      if (is_wr) begin
        bus.req_din[e*8 +: 8]     = d;
        bus.req_din_valid[e]      = 1'b1;
        bus.req_din[other*8 +: 8] = ~d;
        exp_q.push_back(d);
        #1;
        chk("din_valid", bus.eng_din_valid, 1);
        chk("din_data", bus.eng_din, exp_q.pop_front());
        bus.eng_din_taken = 1'b1;
        #1;
        chk("din_taken_route", bus.req_din_taken, oh(e));
        @(negedge clk);
        bus.eng_din_taken    = 1'b0;
        bus.req_din_valid[e] = 1'b0;
      end else begin
        bus.eng_dout       = d;
        bus.eng_dout_avail = 1'b1;
        exp_q.push_back(d);
        #1;
        chk("dout_avail_route", bus.req_dout_avail, oh(e));
        bus.req_dout_taken[e] = 1'b1;
        #1;
        chk("dout_taken_route", bus.eng_dout_taken, 1);
        chk("dout_data", bus.req_dout, exp_q.pop_front());
        @(negedge clk);
        bus.eng_dout_avail    = 1'b0;
        bus.req_dout_taken[e] = 1'b0;
      end
      @(negedge clk);
    end

    if (err_at >= 0 && err_at < 512) @(negedge clk);
    chk("strobe_drop", bus.eng_rd | bus.eng_wr, 0);
    repeat ($urandom_range(1, 3)) @(negedge clk);
    chk("no_done_while_busy", bus.done, 0);
    bus.eng_busy = 1'b0;
    if (err_at >= 0 && err_at < 512) finish_done(e, 1'b1, 3'b010);
    else                             finish_done(e, 1'b0, 3'b000);
    bus.eng_error      = 1'b0;
    bus.eng_error_code = 3'b000;
    chk("one_grant", multi, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    do_reset();
    chk("rst_gnt0", bus.gnt, 0);
    chk("rst_done0", bus.done, 0);
    chk("rst_err0", bus.err, 0);
    chk("rst_code0", bus.err_code, 0);
    chk("rst_rd0", bus.eng_rd, 0);
    chk("rst_wr0", bus.eng_wr, 0);
    chk("rst_addr0", bus.eng_addr, 0);
    chk("rst_dinv0", bus.eng_din_valid, 0);
    chk("rst_doutt0", bus.eng_dout_taken, 0);

    // Single read from requester 0.
    post(0, 1'b0, 32'h0000_0010);
    xfer(-1, -1, 1'b0, -1);
    chk("read_who", got, 0);

    // Write from requester 1.
    post(1, 1'b1, 32'h0000_2000);
    xfer(-1, -1, 1'b0, -1);
    chk("write_who", got, 1);

    // Contention from reset: both request together, one drops req mid-transfer.
    do_reset();
    post(0, 1'($urandom), $urandom);
    post(1, 1'($urandom), $urandom);
    for (int t = 0; t < 4; t++) begin
      xfer(-1, -1, 1'b0, (t == 2) ? 256 : -1);
      chk("rr_order", got, t % 2);
      if (t < 2) post(got, 1'($urandom), $urandom);
    end

    // Start timeout.
    post(0, 1'b0, $urandom);
    xfer(-1, -1, 1'b1, -1);

    // Engine error at byte 100.
    post(1, 1'b1, $urandom);
    xfer(100, -1, 1'b0, -1);

    // Reset in the middle of a read, then a normal transfer.
    post(0, 1'b0, $urandom);
    xfer(-1, 200, 1'b0, -1);
    chk("post_rst_gnt", bus.gnt, 0);
    post(1, 1'b0, $urandom);
    xfer(-1, -1, 1'b0, -1);
    chk("post_rst_who", got, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
